// File: rtl/ctrl_fsm.sv
// ctrl_fsm - sequential control unit for the picoMIPS datapath.
//
// Decodes the instruction opcode into ALU function and datapath strobes and
// adds sequencing: LOAD waits for a synchronised button press and then
// writes exactly once, MULI can stall, HALT is sticky until reset and
// undefined opcodes are flagged.
//
// Optional feature macro: CTRL_MUL_STALL_EN
//   defined   - MULI occupies MUL_LAT cycles, one write on the last cycle
//   undefined - MULI completes in one cycle, no stall counter is built
//
// Parameters:
//   OPW     opcode width (>= 3)
//   AFW     ALUFunc width (>= 2)
//   MUL_LAT total MULI cycles when stalling is compiled in (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   opcode     in   current opcode, held stable while PCincr=0
//   load_btn   in   raw asynchronous load button, active high
//   ALUFunc    out  {zeros, opcode[1:0]}
//   PCincr     out  advance PC at the next edge
//   imm        out  operand B is immediate/switch rather than a register
//   imm_or_sw  out  1 = program immediate, 0 = switches
//   write      out  register-file write enable
//   busy       out  state is not RUN
//   illegal    out  current opcode is undefined
module ctrl_fsm #(
    parameter int unsigned OPW     = 3,
    parameter int unsigned AFW     = 2,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic [OPW-1:0] opcode,
    input  logic           load_btn,
    output logic [AFW-1:0] ALUFunc,
    output logic           PCincr,
    output logic           imm,
    output logic           imm_or_sw,
    output logic           write,
    output logic           busy,
    output logic           illegal
);

    typedef enum logic [1:0] {RUN, WAIT_LOAD, MUL_WAIT, HALTED} state_t;

    typedef enum logic [2:0] {
        OP_HALT = 3'b000,
        OP_ADDI = 3'b001,
        OP_ADD  = 3'b010,
        OP_MULI = 3'b011,
        OP_LOAD = 3'b100
    } opc_t;

    state_t     r_state;
    logic       r_live;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;

    logic [2:0] w_op;
    logic       w_hi_set;
    logic       w_load_pulse;
    logic       w_mul_stall;
    logic       w_mul_done;

    assign w_op         = opcode[2:0];
    // Shift instead of a part-select so OPW == 3 needs no special case.
    assign w_hi_set     = |(opcode >> 3);
    assign w_load_pulse = r_sync2 & ~r_prev;

`ifdef CTRL_MUL_STALL_EN
    localparam int unsigned CW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

    logic [CW-1:0] r_cnt;

    assign w_mul_stall = (MUL_LAT > 1);
    assign w_mul_done  = (r_cnt == '0);

    // The issuing RUN cycle counts as one of the MUL_LAT cycles and the
    // final MUL_WAIT cycle (counter zero) is another, hence MUL_LAT-2.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
        end else if (r_live && r_state == RUN && !w_hi_set && w_op == OP_MULI) begin
            r_cnt <= CW'(MUL_LAT - 2);
        end else if (r_state == MUL_WAIT && !w_mul_done) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
`else
    logic w_unused_mul_lat;

    assign w_mul_stall      = 1'b0;
    assign w_mul_done       = 1'b1;
    assign w_unused_mul_lat = (MUL_LAT != 0);
`endif

    // Button synchroniser plus edge-detect flop. r_live holds the FSM and
    // outputs idle until the first edge after reset release.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_sync1 <= load_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= RUN;
        end else if (r_live) begin
            unique case (r_state)
                RUN: begin
                    if (!w_hi_set) begin
                        case (w_op)
                            OP_LOAD: r_state <= WAIT_LOAD;
                            OP_HALT: r_state <= HALTED;
                            OP_MULI: if (w_mul_stall) r_state <= MUL_WAIT;
                            default: ;
                        endcase
                    end
                end
                WAIT_LOAD: if (w_load_pulse) r_state <= RUN;
                MUL_WAIT:  if (w_mul_done)   r_state <= RUN;
                HALTED:    ;
            endcase
        end
    end

    // Outputs decode combinationally from state and opcode so a
    // single-cycle instruction completes in the cycle it is presented.
    always_comb begin
        ALUFunc   = '0;
        PCincr    = 1'b0;
        imm       = 1'b0;
        imm_or_sw = 1'b0;
        write     = 1'b0;
        busy      = 1'b0;
        illegal   = 1'b0;
        if (r_live) begin
            ALUFunc[1:0] = opcode[1:0];
            busy         = (r_state != RUN);
            unique case (r_state)
                RUN: begin
                    if (w_hi_set) begin
                        illegal = 1'b1;
                        PCincr  = 1'b1;
                    end else begin
                        case (w_op)
                            OP_ADD: begin
                                write  = 1'b1;
                                PCincr = 1'b1;
                            end
                            OP_ADDI: begin
                                write     = 1'b1;
                                PCincr    = 1'b1;
                                imm       = 1'b1;
                                imm_or_sw = 1'b1;
                            end
                            OP_MULI: begin
                                imm       = 1'b1;
                                imm_or_sw = 1'b1;
                                write     = !w_mul_stall;
                                PCincr    = !w_mul_stall;
                            end
                            OP_LOAD: imm = 1'b1;
                            OP_HALT: ;
                            default: begin
                                illegal = 1'b1;
                                PCincr  = 1'b1;
                            end
                        endcase
                    end
                end
                WAIT_LOAD: begin
                    imm    = 1'b1;
                    write  = w_load_pulse;
                    PCincr = w_load_pulse;
                end
                MUL_WAIT: begin
                    imm       = 1'b1;
                    imm_or_sw = 1'b1;
                    write     = w_mul_done;
                    PCincr    = w_mul_done;
                end
                HALTED: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm (OPW=4, AFW=2, MUL_LAT=3).
// A behavioural model predicts every output each cycle; literal checks pin
// the model at the key points of each scenario.
module tb_ctrl_fsm;

    localparam int unsigned OPW     = 4;
    localparam int unsigned AFW     = 2;
    localparam int unsigned MUL_LAT = 3;
`ifdef CTRL_MUL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           nReset;
    logic [OPW-1:0] opcode;
    logic           load_btn;
    logic [AFW-1:0] ALUFunc;
    logic           PCincr, imm, imm_or_sw, write, busy, illegal;

    ctrl_fsm #(.OPW(OPW), .AFW(AFW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .nReset(nReset), .opcode(opcode), .load_btn(load_btn),
        .ALUFunc(ALUFunc), .PCincr(PCincr), .imm(imm), .imm_or_sw(imm_or_sw),
        .write(write), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Output vector layout: {ALUFunc, PCincr, imm, imm_or_sw, write, busy, illegal}
    logic [7:0] w_act;
    assign w_act = {ALUFunc, PCincr, imm, imm_or_sw, write, busy, illegal};

    function automatic logic [7:0] pack(logic [1:0] a, logic p, logic i, logic s,
                                        logic w, logic b, logic il);
        return {a, p, i, s, w, b, il};
    endfunction

    task automatic chk(string name, logic [7:0] exp_v);
        checks++;
        if (w_act === exp_v) passes++;
        else $display("FAIL %s t=%0t {alu,pc,imm,isw,wr,busy,ill} got=%b expected=%b",
                      name, $time, w_act, exp_v);
    endtask

    // ---------------- behavioural model ----------------
    bit m_live = 0, m_halted = 0, m_loading = 0;
    int m_mul_left = 0;                 // remaining MULI stall cycles
    bit h0 = 0, h1 = 0, h2 = 0;         // button samples at the last three edges

    function automatic void m_reset();
        m_live = 0; m_halted = 0; m_loading = 0; m_mul_left = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endfunction

    function automatic logic [7:0] m_expect();
        int   op;
        logic p, i, s, w, b, il;
        op = int'(opcode);
        p = 0; i = 0; s = 0; w = 0; b = 0; il = 0;
        if (!nReset || !m_live) return '0;
        if (m_halted) b = 1;
        else if (m_loading) begin
            b = 1; i = 1;
            if (h1 && !h2) begin w = 1; p = 1; end
        end else if (m_mul_left > 0) begin
            b = 1; i = 1; s = 1;
            if (m_mul_left == 1) begin w = 1; p = 1; end
        end else if (op > 4) begin
            il = 1; p = 1;
        end else begin
            case (op)
                1: begin w = 1; p = 1; i = 1; s = 1; end
                2: begin w = 1; p = 1; end
                3: begin
                    i = 1; s = 1;
                    if (!(STALL && MUL_LAT > 1)) begin w = 1; p = 1; end
                end
                4: i = 1;
                default: ;
            endcase
        end
        return pack(opcode[1:0], p, i, s, w, b, il);
    endfunction

    function automatic void m_advance();
        bit pulse;
        int op;
        pulse = h1 && !h2;
        op    = int'(opcode);
        if (!m_live) m_live = 1;
        else if (m_halted) ;
        else if (m_loading) begin
            if (pulse) m_loading = 0;
        end else if (m_mul_left > 0) m_mul_left--;
        else begin
            case (op)
                0: m_halted = 1;
                3: if (STALL && MUL_LAT > 1) m_mul_left = MUL_LAT - 1;
                4: m_loading = 1;
                default: ;
            endcase
        end
        h2 = h1; h1 = h0; h0 = load_btn;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!nReset) m_reset();
            chk("cycle", m_expect());
            @(posedge clk);
            if (nReset) m_advance();
            else m_reset();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string name, logic [7:0] e);
        @(negedge clk);
        chk(name, e);
    endtask

    initial begin
        nReset = 1'b1; opcode = 4'b0010; load_btn = 1'b0;
        #2 nReset = 1'b0;
        cyc(); cyc(); cyc();
        lit("reset_hold", '0);
        cyc(); nReset = 1'b1;
        lit("release_gap", '0);
        cyc();
        lit("add", pack(2'b10, 1, 0, 0, 1, 0, 0));
        cyc(); opcode = 4'b0001;
        lit("addi", pack(2'b01, 1, 1, 1, 1, 0, 0));
        cyc(); opcode = 4'b0110;
        lit("illegal_110", pack(2'b10, 1, 0, 0, 0, 0, 1));
        cyc(); opcode = 4'b1010;
        lit("illegal_hi", pack(2'b10, 1, 0, 0, 0, 0, 1));

        // LOAD, press, single write two edges after the press
        cyc(); opcode = 4'b0100;
        lit("load_issue", pack(2'b00, 0, 1, 0, 0, 0, 0));
        cyc(); load_btn = 1'b1;
        lit("load_wait", pack(2'b00, 0, 1, 0, 0, 1, 0));
        cyc();
        lit("load_sync", pack(2'b00, 0, 1, 0, 0, 1, 0));
        cyc();
        lit("load_write", pack(2'b00, 1, 1, 0, 1, 1, 0));
        // second LOAD while the button is still held: needs a fresh edge
        cyc(); opcode = 4'b0100;
        lit("load2_issue", pack(2'b00, 0, 1, 0, 0, 0, 0));
        cyc();
        lit("load2_held", pack(2'b00, 0, 1, 0, 0, 1, 0));
        cyc(); load_btn = 1'b0;
        lit("load2_nopulse", pack(2'b00, 0, 1, 0, 0, 1, 0));
        cyc(); cyc(); load_btn = 1'b1;
        cyc(); cyc();
        lit("load2_write", pack(2'b00, 1, 1, 0, 1, 1, 0));

        // MULI held for three cycles
        cyc(); opcode = 4'b0011; load_btn = 1'b0;
        lit("muli_0", STALL ? pack(2'b11, 0, 1, 1, 0, 0, 0) : pack(2'b11, 1, 1, 1, 1, 0, 0));
        cyc();
        lit("muli_1", STALL ? pack(2'b11, 0, 1, 1, 0, 1, 0) : pack(2'b11, 1, 1, 1, 1, 0, 0));
        cyc();
        lit("muli_2", STALL ? pack(2'b11, 1, 1, 1, 1, 1, 0) : pack(2'b11, 1, 1, 1, 1, 0, 0));

        // HALT is sticky; only reset recovers
        cyc(); opcode = 4'b0000;
        lit("halt_issue", '0);
        cyc(); opcode = 4'b0010;
        lit("halted", pack(2'b10, 0, 0, 0, 0, 1, 0));
        cyc(); cyc(); cyc();
        lit("halted_late", pack(2'b10, 0, 0, 0, 0, 1, 0));
        cyc(); nReset = 1'b0;
        lit("halt_reset", '0);
        cyc(); nReset = 1'b1;
        cyc();
        lit("add_after_reset", pack(2'b10, 1, 0, 0, 1, 0, 0));

        // reset inside WAIT_LOAD, then a press while in RUN is ignored
        cyc(); opcode = 4'b0100;
        cyc();
        cyc(); nReset = 1'b0;
        lit("wait_load_reset", '0);
        cyc(); nReset = 1'b1; opcode = 4'b0101;
        cyc(); load_btn = 1'b1;
        lit("nop_after_reset", pack(2'b01, 1, 0, 0, 0, 0, 1));
        cyc(); cyc(); cyc();
        lit("press_ignored", pack(2'b01, 1, 0, 0, 0, 0, 1));
        cyc(); load_btn = 1'b0;

        // reset during a MULI (mid-stall when stalling is built in)
        cyc(); opcode = 4'b0011;
        cyc();
        cyc(); nReset = 1'b0;
        lit("mul_reset", '0);
        cyc(); nReset = 1'b1; opcode = 4'b0010;
        cyc();
        lit("add_after_mul_reset", pack(2'b10, 1, 0, 0, 1, 0, 0));
        cyc(); cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
